// File: rtl/bin_frame_pingpong_buffer.sv
// Ping-pong binary frame buffer: binarises a raster pixel stream into two banks of
// IMG_W x IMG_H bits, filling one bank while the other is presented to the consumer.
module bin_frame_pingpong_buffer #(
  parameter int unsigned IMG_W    = 28,
  parameter int unsigned IMG_H    = 28,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BIN_MODE = 0,
  parameter int unsigned THRESH   = 128,
  localparam int unsigned N_PIX   = IMG_W * IMG_H,
  localparam int unsigned ADDR_W  = $clog2(N_PIX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_buffer,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [N_PIX-1:0]  image_flat,
  output logic [ADDR_W-1:0] write_addr,
  output logic              fill_bank,
  output logic              full,
  output logic              empty,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [DATA_W-1:0] THRESH_C  = DATA_W'(THRESH);

  function automatic logic binarise(input logic [DATA_W-1:0] d);
    logic b;
    if (BIN_MODE != 32'd0) begin
      b = (d >= THRESH_C);
    end else begin
      b = d[0];
    end
    return b;
  endfunction

  logic [1:0][N_PIX-1:0] bank_r;
  logic [1:0]            bank_full_r;
  logic [1:0]            bank_full_nxt_s;
  logic                  wr_bank_r;
  logic                  rd_bank_r;
  logic                  overrun_r;
  logic [ADDR_W-1:0]     write_addr_r;
  logic                  accept_s;
  logic                  last_s;
  logic                  ack_s;

  // Handshake decode and next bank_full flags; a completing fill and an ack always hit different banks.
  always_comb begin
    accept_s        = in_valid && !bank_full_r[wr_bank_r];
    last_s          = accept_s && (write_addr_r == LAST_ADDR);
    ack_s           = frame_ack && bank_full_r[rd_bank_r];
    bank_full_nxt_s = bank_full_r;
    if (last_s && !clear_buffer) begin
      bank_full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      bank_full_nxt_s[wr_bank_r] = bank_full_r[wr_bank_r];
    end
    if (ack_s) begin
      bank_full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      bank_full_nxt_s[rd_bank_r] = bank_full_nxt_s[rd_bank_r];
    end
  end

  // Bank pointers, fill address, completion flags and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full_r  <= 2'b00;
      wr_bank_r    <= 1'b0;
      rd_bank_r    <= 1'b0;
      write_addr_r <= '0;
      overrun_r    <= 1'b0;
    end else begin
      bank_full_r <= bank_full_nxt_s;
      if (ack_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      if (clear_buffer) begin
        write_addr_r <= '0;
        overrun_r    <= 1'b0;
      end else begin
        if (in_valid && bank_full_r[wr_bank_r]) begin
          overrun_r <= 1'b1;
        end
        if (last_s) begin
          write_addr_r <= '0;
          wr_bank_r    <= ~wr_bank_r;
        end else if (accept_s) begin
          write_addr_r <= write_addr_r + ADDR_W'(1);
        end
      end
    end
  end

  // Bank storage: an abort wipes only a partially filled bank, never a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r <= '0;
    end else if (clear_buffer) begin
      if (!bank_full_r[wr_bank_r]) begin
        bank_r[wr_bank_r] <= '0;
      end
    end else if (accept_s) begin
      bank_r[wr_bank_r][write_addr_r] <= binarise(data_in);
    end
  end

  assign in_ready    = !bank_full_r[wr_bank_r];
  assign frame_valid = bank_full_r[rd_bank_r];
  assign image_flat  = bank_r[rd_bank_r];
  assign write_addr  = write_addr_r;
  assign fill_bank   = wr_bank_r;
  assign full        = bank_full_r[0] && bank_full_r[1];
  assign empty       = (write_addr_r == '0) && (bank_full_r == 2'b00);
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_bin_frame_pingpong_buffer.sv
// Directed bench for bin_frame_pingpong_buffer: a frame-queue model checked every cycle on
// two instances (LSB and threshold binarisation) plus hand-computed literal expectations.
module tb_bin_frame_pingpong_buffer;
  localparam int N  = 784;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_buffer = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic in_valid = 1'b0;
  logic frame_ack = 1'b0;

  logic in_ready0, frame_valid0, fill_bank0, full0, empty0, overrun0;
  logic in_ready1, frame_valid1, fill_bank1, full1, empty1, overrun1;
  logic [N-1:0]  img0, img1;
  logic [AW-1:0] wa0, wa1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bin_frame_pingpong_buffer #(.BIN_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear_buffer(clear_buffer), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready0), .frame_valid(frame_valid0),
    .frame_ack(frame_ack), .image_flat(img0), .write_addr(wa0), .fill_bank(fill_bank0),
    .full(full0), .empty(empty0), .overrun(overrun0));

  bin_frame_pingpong_buffer #(.BIN_MODE(1), .THRESH(128)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear_buffer(clear_buffer), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready1), .frame_valid(frame_valid1),
    .frame_ack(frame_ack), .image_flat(img1), .write_addr(wa1), .fill_bank(fill_bank1),
    .full(full1), .empty(empty1), .overrun(overrun1));

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_v(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Behavioural model: completed frames queue up in order, the head is what is presented.
  logic [N-1:0] q0[$];
  logic [N-1:0] q1[$];
  logic [N-1:0] p0, p1;
  int  cnt, done;
  bit  ov;

  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete(); q1.delete();
        p0 = '0; p1 = '0; cnt = 0; done = 0; ov = 1'b0;
      end else begin
        chk_i("m_in_ready", int'(in_ready0), int'(q0.size() < 2));
        chk_i("m_frame_valid", int'(frame_valid0), int'(q0.size() > 0));
        chk_i("m_full", int'(full0), int'(q0.size() == 2));
        chk_i("m_empty", int'(empty0), int'(cnt == 0 && q0.size() == 0));
        chk_i("m_fill_bank", int'(fill_bank0), done % 2);
        chk_i("m_write_addr", int'(wa0), cnt);
        chk_i("m_overrun", int'(overrun0), int'(ov));
        chk_i("m_frame_valid1", int'(frame_valid1), int'(q1.size() > 0));
        chk_i("m_write_addr1", int'(wa1), cnt);
        if (q0.size() > 0) begin
          chk_v("m_image0", img0, q0[0]);
          chk_v("m_image1", img1, q1[0]);
        end
        // advance the model with the inputs the next rising edge will see
        begin
          bit rdy, ack;
          rdy = (q0.size() < 2);
          ack = frame_ack && (q0.size() > 0);
          if (clear_buffer) begin
            cnt = 0; ov = 1'b0;
          end else begin
            if (in_valid && !rdy) ov = 1'b1;
            if (in_valid && rdy) begin
              p0[cnt] = data_in[0];
              p1[cnt] = (data_in >= 8'd128);
              cnt++;
              if (cnt == N) begin
                q0.push_back(p0); q1.push_back(p1);
                cnt = 0; done++;
              end
            end
          end
          if (ack) begin
            void'(q0.pop_front()); void'(q1.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [7:0] pix(input int pat, input int i);
    case (pat)
      0: return 8'(i % 2);
      1: return 8'hFF;
      2: case (i % 4)
           0: return 8'd127;
           1: return 8'd128;
           2: return 8'd255;
           default: return 8'd0;
         endcase
      3: return 8'((i + 1) % 2);
      default: return 8'h00;
    endcase
  endfunction

  task automatic stream(input int n, input int pat, input bit ack_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      data_in = pix(pat, i);
      frame_ack = ack_last && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic pulse_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_buffer = 1'b1;
    @(posedge clk); #1;
    clear_buffer = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_i({tag, "_in_ready"}, int'(in_ready0), 1);
    chk_i({tag, "_frame_valid"}, int'(frame_valid0), 0);
    chk_v({tag, "_image0"}, img0, '0);
    chk_v({tag, "_image1"}, img1, '0);
    chk_i({tag, "_full"}, int'(full0), 0);
    chk_i({tag, "_empty"}, int'(empty0), 1);
    chk_i({tag, "_fill_bank"}, int'(fill_bank0), 0);
    chk_i({tag, "_write_addr"}, int'(wa0), 0);
    chk_i({tag, "_overrun"}, int'(overrun0), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] pat_alt10, pat_alt01, pat_0101, pat_0110, ones;
    pat_alt10 = {392{2'b10}};
    pat_alt01 = {392{2'b01}};
    pat_0101  = {196{4'b0101}};
    pat_0110  = {196{4'b0110}};
    ones      = '1;

    #12;
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // first frame: LSB pattern i%2
    stream(N - 1, 0, 1'b0);
    chk_i("pre_last_frame_valid", int'(frame_valid0), 0);
    in_valid = 1'b1; data_in = pix(0, N - 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_i("f1_frame_valid", int'(frame_valid0), 1);
    chk_v("f1_image0", img0, pat_alt10);
    chk_v("f1_image1", img1, '0);
    chk_i("f1_fill_bank", int'(fill_bank0), 1);
    chk_i("f1_write_addr", int'(wa0), 0);
    chk_i("f1_empty", int'(empty0), 0);

    // second frame without ack fills both banks
    stream(N, 1, 1'b0);
    chk_i("both_full", int'(full0), 1);
    chk_i("both_in_ready", int'(in_ready0), 0);
    in_valid = 1'b1; data_in = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_i("ovr_set", int'(overrun0), 1);
    chk_v("ovr_image_held", img0, pat_alt10);
    pulse_ack();
    chk_v("ack_image_bank1", img0, ones);
    chk_i("ack_in_ready", int'(in_ready0), 1);
    chk_i("ack_full", int'(full0), 0);
    pulse_ack();
    chk_i("ack2_frame_valid", int'(frame_valid0), 0);
    chk_i("ack2_empty", int'(empty0), 1);

    // threshold binarisation: 127,128,255,0 repeating
    stream(N, 2, 1'b0);
    chk_v("thr_image1", img1, pat_0110);
    chk_v("lsb_image0", img0, pat_0101);
    pulse_ack();

    // abort a partial fill, then a full frame of 0xFF
    stream(300, 4, 1'b0);
    chk_i("part_write_addr", int'(wa0), 300);
    pulse_clear();
    chk_i("clr_write_addr", int'(wa0), 0);
    chk_i("clr_empty", int'(empty0), 1);
    chk_i("clr_overrun", int'(overrun0), 0);
    stream(N, 1, 1'b0);
    chk_v("clr_frame_ones0", img0, ones);
    chk_v("clr_frame_ones1", img1, ones);

    // last pixel of next frame coincides with ack of the presented one
    stream(N, 3, 1'b1);
    chk_i("sim_frame_valid", int'(frame_valid0), 1);
    chk_v("sim_image0", img0, pat_alt01);
    chk_v("sim_image1", img1, '0);
    chk_i("sim_full", int'(full0), 0);
    chk_i("sim_in_ready", int'(in_ready0), 1);
    pulse_ack();

    // reset mid-fill with a frame presented
    stream(N, 0, 1'b0);
    stream(500, 1, 1'b0);
    chk_i("mid_write_addr", int'(wa0), 500);
    chk_i("mid_frame_valid", int'(frame_valid0), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    rst_n = 1'b1;
    pulse_ack();
    chk_i("idle_ack_frame_valid", int'(frame_valid0), 0);
    chk_i("idle_ack_empty", int'(empty0), 1);
    chk_i("idle_ack_in_ready", int'(in_ready0), 1);
    stream(N, 3, 1'b0);
    chk_i("post_ack_frame_valid", int'(frame_valid0), 1);
    chk_v("post_ack_image0", img0, pat_alt01);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
